// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: data width, opcodes, FSM encoding.
package alu_arbiter_pkg;

   localparam int unsigned W     = 16;
   localparam int unsigned N_REQ = 2;
   localparam int unsigned OP_W  = 4;
   localparam int unsigned CNT_W = 16;

   localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
   localparam logic [OP_W-1:0] OP_RST  = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0100;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0101;
   localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
   localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b1010;
   localparam logic [OP_W-1:0] OP_NAND = 4'b1011;
   localparam logic [OP_W-1:0] OP_NOR  = 4'b1100;
   localparam logic [OP_W-1:0] OP_NOT  = 4'b1101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_e;

   function automatic logic op_legal(input logic [OP_W-1:0] op);
      case (op)
         OP_NOP, OP_RST, OP_ADD, OP_SUB, OP_AND,
         OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_NOT: op_legal = 1'b1;
         default:                                op_legal = 1'b0;
      endcase
   endfunction

   // NOP and RST produce a zero result whatever the ALU drives.
   function automatic logic op_zero(input logic [OP_W-1:0] op);
      op_zero = (op == OP_NOP) || (op == OP_RST);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin picker: sole requester wins, ties go to the one not granted last.
module rr_pick2
   import alu_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic             last,
   output logic [N_REQ-1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU (IDLE -> ISSUE -> RESP).
// Build option: define ALU_ARB_OPCHECK_EN to flag illegal opcodes via rsp_err.
module alu_arbiter #(
   parameter int unsigned W = alu_arbiter_pkg::W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [2*W-1:0]   req_a,
   input  logic [2*W-1:0]   req_b,
   input  logic [7:0]       req_op,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic [3:0]       alu_opcode,
   input  logic [W-1:0]     alu_result,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [W-1:0]     rsp_data,
   output logic             rsp_err,
   output logic             busy,
   output logic [15:0]      done_cnt
);
   import alu_arbiter_pkg::*;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic             idx_q, idx_d;
   logic [W-1:0]     alu_a_q, alu_a_d;
   logic [W-1:0]     alu_b_q, alu_b_d;
   logic [OP_W-1:0]  alu_op_q, alu_op_d;
   logic [W-1:0]     rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

   logic [1:0]       grant_c;
   logic             gidx_c;
   logic [W-1:0]     a_sel_c, b_sel_c;
   logic [OP_W-1:0]  op_sel_c;
   logic             illegal_c;
   logic             accept_c;
   logic             rsp_hs_c;

   rr_pick2 u_rr (
      .req   (req_valid),
      .last  (last_q),
      .grant (grant_c)
   );

   assign gidx_c   = grant_c[1];
   assign a_sel_c  = gidx_c ? req_a[2*W-1:W] : req_a[W-1:0];
   assign b_sel_c  = gidx_c ? req_b[2*W-1:W] : req_b[W-1:0];
   assign op_sel_c = gidx_c ? req_op[7:4]    : req_op[3:0];
   assign accept_c = (state_q == S_IDLE) && (req_valid != 2'b00);
   assign rsp_hs_c = (state_q == S_RESP) && rsp_ready[idx_q];

`ifdef ALU_ARB_OPCHECK_EN
   assign illegal_c = !op_legal(op_sel_c);
`else
   assign illegal_c = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         last_q     <= 1'b1;
         idx_q      <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         rsp_data_q <= '0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         idx_q      <= idx_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         rsp_data_q <= rsp_data_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      idx_d      = idx_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      rsp_data_d = rsp_data_q;
      done_cnt_d = done_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               state_d  = S_ISSUE;
               idx_d    = gidx_c;
               last_d   = gidx_c;
               alu_a_d  = a_sel_c;
               alu_b_d  = b_sel_c;
               // Illegal opcodes are squashed to NOP so the result is forced to zero.
               alu_op_d = illegal_c ? OP_NOP : op_sel_c;
            end
         end
         S_ISSUE: begin
            state_d    = S_RESP;
            rsp_data_d = op_zero(alu_op_q) ? '0 : alu_result;
         end
         S_RESP: begin
            if (rsp_hs_c) begin
               state_d    = S_IDLE;
               done_cnt_d = done_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef ALU_ARB_OPCHECK_EN
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept_c) begin
         err_q <= illegal_c;
      end
   end

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // req_ready is the only combinational output; suppressed while reset is asserted.
   assign req_ready  = ((state_q == S_IDLE) && !rst) ? grant_c : 2'b00;
   assign rsp_valid  = (state_q == S_RESP) ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
   assign busy       = (state_q != S_IDLE);
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign rsp_data   = rsp_data_q;
   assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [7:0]  req_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_result;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        busy;
   logic [15:0] done_cnt;

   int n_vec = 0;
   int n_err = 0;

   alu_arbiter #(.W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .done_cnt   (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU; NOP/RST return a nonzero pattern so the arbiter's zeroing is visible.
   always_comb begin
      case (alu_opcode)
         4'b0100: alu_result = alu_a + alu_b;
         4'b0101: alu_result = alu_a - alu_b;
         4'b1000: alu_result = alu_a & alu_b;
         4'b1001: alu_result = alu_a | alu_b;
         4'b1010: alu_result = alu_a ^ alu_b;
         4'b1011: alu_result = ~(alu_a & alu_b);
         4'b1100: alu_result = ~(alu_a | alu_b);
         4'b1101: alu_result = ~alu_a;
         4'b0000, 4'b0001: alu_result = 16'h5A5A;
         default: alu_result = 16'h1234;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Requester 0 alone, response taken immediately; ends on the next IDLE negedge.
   task automatic run_op0(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
      req_a[15:0] = a;
      req_b[15:0] = b;
      req_op[3:0] = op;
      req_valid   = 2'b01;
      rsp_ready   = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_alu_a", 32'(alu_a), 32'h0);
      chk("rst_alu_b", 32'(alu_b), 32'h0);
      chk("rst_alu_opcode", 32'(alu_opcode), 32'h0);
      chk("rst_done_cnt", 32'(done_cnt), 32'h0);
      req_valid = 2'b00;
      rst       = 1'b0;
      @(negedge clk);

      // Single ADD from requester 0: 3 + 4, response two cycles after acceptance.
      req_a     = {16'h0000, 16'h0003};
      req_b     = {16'h0000, 16'h0004};
      req_op    = {4'b0000, 4'b0100};
      req_valid = 2'b01;
      #1;
      chk("add_req_ready", 32'(req_ready), 32'h1);
      chk("add_busy_idle", 32'(busy), 32'h0);
      @(negedge clk);
      chk("add_issue_ready", 32'(req_ready), 32'h0);
      chk("add_issue_busy", 32'(busy), 32'h1);
      chk("add_issue_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("add_alu_a", 32'(alu_a), 32'h0003);
      chk("add_alu_b", 32'(alu_b), 32'h0004);
      chk("add_alu_opcode", 32'(alu_opcode), 32'h4);
      req_valid = 2'b00;
      @(negedge clk);
      chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("add_rsp_data", 32'(rsp_data), 32'h0007);
      chk("add_rsp_err", 32'(rsp_err), 32'h0);
      chk("add_done_before", 32'(done_cnt), 32'h0);
      rsp_ready = 2'b01;
      @(negedge clk);
      chk("add_rsp_valid_drop", 32'(rsp_valid), 32'h0);
      chk("add_busy_after", 32'(busy), 32'h0);
      chk("add_done_cnt", 32'(done_cnt), 32'h1);
      rsp_ready = 2'b00;

      // Both requesting after reset: grants alternate 0,1,0,1.
      do_reset();
      req_a     = {16'hF0F0, 16'h000A};
      req_b     = {16'hFF00, 16'h0001};
      req_op    = {4'b1010, 4'b0100};
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("rr%0d_req_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("rr%0d_rsp_data", k), 32'(rsp_data), (k % 2 == 0) ? 32'h000B : 32'h0FF0);
         @(negedge clk);
      end
      chk("rr_done_cnt", 32'(done_cnt), 32'h4);

      // SUB 0-1 with response stalled; non-granted rsp_ready bit must be ignored.
      req_a[15:0] = 16'h0000;
      req_b[15:0] = 16'h0001;
      req_op[3:0] = 4'b0101;
      req_valid   = 2'b11;
      rsp_ready   = 2'b10;
      #1;
      chk("sub_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("stall%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
         chk($sformatf("stall%0d_rsp_data", i), 32'(rsp_data), 32'hFFFF);
         chk($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'h0);
         if (i < 5) @(negedge clk);
      end
      rsp_ready = 2'b01;
      req_valid = 2'b00;
      @(negedge clk);
      chk("stall_release_valid", 32'(rsp_valid), 32'h0);
      chk("stall_done_cnt", 32'(done_cnt), 32'h5);

      // Illegal opcode 0111 from requester 1.
      req_a[31:16] = 16'h0005;
      req_b[31:16] = 16'h0003;
      req_op[7:4]  = 4'b0111;
      req_valid    = 2'b10;
      rsp_ready    = 2'b10;
      #1;
      chk("ill_req_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
`ifdef ALU_ARB_OPCHECK_EN
      chk("ill_alu_opcode", 32'(alu_opcode), 32'h0);
`else
      chk("ill_alu_opcode", 32'(alu_opcode), 32'h7);
`endif
      req_valid = 2'b00;
      @(negedge clk);
      chk("ill_rsp_valid", 32'(rsp_valid), 32'h2);
`ifdef ALU_ARB_OPCHECK_EN
      chk("ill_rsp_err", 32'(rsp_err), 32'h1);
      chk("ill_rsp_data", 32'(rsp_data), 32'h0000);
`else
      chk("ill_rsp_err", 32'(rsp_err), 32'h0);
      chk("ill_rsp_data", 32'(rsp_data), 32'h1234);
`endif
      @(negedge clk);
      chk("ill_done_cnt", 32'(done_cnt), 32'h6);

      // NOP yields zero even though the ALU drives a pattern.
      run_op0(16'h0009, 16'h0002, 4'b0000);
      chk("nop_done_cnt", 32'(done_cnt), 32'h7);
      chk("nop_rsp_data", 32'(rsp_data), 32'h0000);

      // Reset while in ISSUE discards the operation.
      req_a[15:0] = 16'h0001;
      req_b[15:0] = 16'h0002;
      req_op[3:0] = 4'b0100;
      req_valid   = 2'b01;
      rsp_ready   = 2'b01;
      @(negedge clk);
      chk("rstmid_busy_issue", 32'(busy), 32'h1);
      req_valid = 2'b00;
      rst       = 1'b1;
      #1;
      chk("rstmid_busy", 32'(busy), 32'h0);
      chk("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rstmid_done_cnt", 32'(done_cnt), 32'h0);
      chk("rstmid_alu_opcode", 32'(alu_opcode), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_no_rsp", 32'(rsp_valid), 32'h0);
      chk("rstmid_idle", 32'(busy), 32'h0);
      req_a[15:0] = 16'hF0F0;
      req_b[15:0] = 16'h3C3C;
      req_op[3:0] = 4'b1000;
      req_valid   = 2'b01;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("post_rst_rsp_data", 32'(rsp_data), 32'h3030);
      @(negedge clk);
      chk("post_rst_done_cnt", 32'(done_cnt), 32'h1);

      // Counter wrap: preload near the top instead of running 65536 handshakes.
      force dut.done_cnt_q = 16'hFFFE;
      #1;
      release dut.done_cnt_q;
      chk("wrap_preload", 32'(done_cnt), 32'hFFFE);
      run_op0(16'h0000, 16'h0000, 4'b0100);
      chk("wrap_ffff", 32'(done_cnt), 32'hFFFF);
      run_op0(16'h0000, 16'h0000, 4'b0100);
      chk("wrap_zero", 32'(done_cnt), 32'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, 16, operand/result width; only 16 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  input  2  bit i = requester i presents an operation.
REQ-005 Port: req_ready  output  2  bit i = requester i's operation accepted this cycle.
REQ-006 Port: req_a  input  2*W  lane i (bits i*W+:W) = operand A of requester i.
REQ-007 Port: req_b  input  2*W  lane i = operand B of requester i.
REQ-008 Port: req_op  input  8  nibble i = 4-bit opcode of requester i.
REQ-009 Port: alu_a, alu_b  output  W each  operands driven to the shared ALU.
REQ-010 Port: alu_opcode  output  4  opcode driven to the shared ALU.
REQ-011 Port: alu_result  input  W  combinational ALU result.
REQ-012 Port: rsp_valid  output  2  bit i = response pending for requester i; at most one bit set.
REQ-013 Port: rsp_ready  input  2  bit i = requester i accepts its response.
REQ-014 Port: rsp_data  output  W  result, valid while any rsp_valid bit is set.
REQ-015 Port: rsp_err  output  1  illegal-opcode flag, qualified as rsp_data.
REQ-016 Port: busy  output  1  high in any state other than IDLE.
REQ-017 Port: done_cnt  output  16  completed-response count.

Function
REQ-018 Opcodes SHALL be: 0000 NOP, 0001 RST, 0100 ADD, 0101 SUB, 1000 AND, 1001 OR, 1010 XOR, 1011 NAND, 1100 NOR, 1101 NOT; all others illegal.
REQ-019 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE on any req_valid, ISSUE->RESP unconditionally, RESP->IDLE when rsp_ready of the granted requester is high.
REQ-020 In IDLE, req_ready SHALL be combinational: one-hot on the granted requester when req_valid is nonzero, else 0; req_ready SHALL be 0 in ISSUE and RESP.
REQ-021 Grant SHALL be round-robin: a sole requester wins; on simultaneous requests the requester not granted last wins.
REQ-022 On acceptance, the granted requester's lanes SHALL be registered into alu_a/alu_b/alu_opcode and its index stored.
REQ-023 In ISSUE, alu_result SHALL be sampled into rsp_data; NOP and RST SHALL yield rsp_data=0.
REQ-024 rsp_valid SHALL assert on the cycle after ISSUE and hold with rsp_data/rsp_err stable until handshake; latency is 2 cycles from acceptance edge to rsp_valid, minimum 3 cycles per operation.
REQ-025 rsp_ready high before rsp_valid SHALL have no effect; rsp_ready on the non-granted bit SHALL be ignored.
REQ-026 done_cnt SHALL increment by 1 on each response handshake and wrap from 0xFFFF to 0x0000.
REQ-027 alu_a/alu_b/alu_opcode SHALL hold their last values outside ISSUE.

Reset
REQ-028 rst SHALL immediately force IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, alu_a=alu_b=0, alu_opcode=0000, busy=0, done_cnt=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-029 An operation in flight at reset SHALL be discarded with no response.

Configuration
REQ-030 Macro ALU_ARB_OPCHECK_EN defined: illegal opcodes SHALL complete with rsp_err=1, rsp_data=0, alu_opcode driven 0000.
REQ-031 Macro undefined: opcodes SHALL pass through unchecked and rsp_err SHALL be tied 0.

Structure
REQ-032 A shared package SHALL hold the opcode constants, W, and the FSM state encoding.
REQ-033 Round-robin selection SHALL be one sub-module, rr_pick2 (inputs: req, last; output: one-hot grant).

Verification
REQ-034 req_valid=01, A=0x0003, B=0x0004, op=0100 -> req_ready=01 at T0, rsp_valid=01 at T0+2, rsp_data=0x0007, done_cnt=1.
REQ-035 req_valid=11 held after reset -> grant order 0,1,0,1; each rsp_valid bit set only for the granted requester.
REQ-036 op=0101, A=0x0000, B=0x0001 -> rsp_data=0xFFFF; rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable, no new grant.
REQ-037 op=0111 with ALU_ARB_OPCHECK_EN -> rsp_err=1, rsp_data=0; without the macro -> rsp_err=0.
REQ-038 rst asserted in ISSUE -> same-cycle return to IDLE, rsp_valid=0, no response emitted; next request is serviced normally.
REQ-039 65536 handshakes -> done_cnt wraps to 0x0000.
